// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg: format codes, RV32I opcodes, immediate ranges and FSM states for inst_encoder
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_LOAD, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
    } fmt_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_J    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -1048576;
    localparam int IMMJ_MAX  = 1048574;

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return $signed(v) >= lo && $signed(v) <= hi;
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// inst_enc_fifo: 2-entry FIFO carrying {addr, data}; push ignored when full, pop ignored when empty
module inst_enc_fifo #(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wp, rp, do_push, do_pop;
    logic [1:0]   cnt;

    assign full    = cnt == 2'd2;
    assign empty   = cnt == 2'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= !wp;
            end
            if (do_pop) rp <= !rp;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: assembles RV32I words from decoded fields and streams them to instruction memory
// Optional immediate/format rejection is enabled by defining INST_ENC_CHECK_EN.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [31:0]          out_data,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    state_e            state;
    fmt_e              fmt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              last_seen, fifo_full, fifo_empty, accept, push, bad, shift;

    assign fmt      = fmt_e'(in_fmt);
    assign shift    = fmt == FMT_I && (in_funct3 == 3'b001 || in_funct3 == 3'b101);
    assign in_ready = state == S_RUN && !fifo_full && !last_seen;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !bad;
    assign out_valid = !fifo_empty;

    always_comb begin
        word = NOP;
        case (fmt)
            FMT_R:    word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            FMT_I:    word = {shift ? {in_funct7, in_imm[4:0]} : in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
            FMT_LOAD: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            FMT_S:    word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
            FMT_B:    word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], OP_B};
            FMT_U:    word = {in_imm[31:12], in_rd, OP_U};
            FMT_J:    word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
            default:  word = NOP;
        endcase
    end

`ifdef INST_ENC_CHECK_EN
    always_comb begin
        bad = 1'b0;
        case (fmt)
            FMT_I:         bad = shift ? !in_range(in_imm, 0, SHAMT_MAX) : !in_range(in_imm, IMM12_MIN, IMM12_MAX);
            FMT_LOAD,
            FMT_S:         bad = !in_range(in_imm, IMM12_MIN, IMM12_MAX);
            FMT_B:         bad = !in_range(in_imm, IMMB_MIN, IMMB_MAX) || in_imm[0];
            FMT_J:         bad = !in_range(in_imm, IMMJ_MIN, IMMJ_MAX) || in_imm[0];
            FMT_U:         bad = in_imm[11:0] != 12'd0;
            FMT_ILL:       bad = 1'b1;
            default:       bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && bad;
            if (accept && bad && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    assign bad     = 1'b0;
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

    // A rejected in_last still closes the program, so last_seen follows accept, not push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state     <= S_RUN;
                    addr      <= base_addr;
                    last_seen <= 1'b0;
                    done      <= 1'b0;
                end
                S_RUN: begin
                    if (push) addr <= addr + ADDR_W'(1);
                    if (accept && in_last) last_seen <= 1'b1;
                    if (last_seen && fifo_empty) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    inst_enc_fifo #(.W(ADDR_W + 32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_ready),
        .din   ({addr, word}),
        .dout  ({out_addr, out_data}),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized scoreboard bench for inst_encoder
`timescale 1ns/1ps
module tb_inst_encoder;
    localparam int AW = 10;
    localparam int EW = 8;
`ifdef INST_ENC_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [2:0]    in_fmt = '0, in_funct3 = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid, out_ready, done, err;
    logic          rdy_man = 1'b0, rdy_rnd = 1'b0, rnd_mode = 1'b0;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_data;
    logic [EW-1:0] err_cnt;

    int               tests = 0, fails = 0, ecnt = 0;
    logic [AW+31:0]   q[$];
    logic [AW+31:0]   head;
    logic [AW-1:0]    addr_m = '0;

    assign out_ready = rnd_mode ? rdy_rnd : rdy_man;

    inst_encoder #(.ADDR_W(AW), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rdy_rnd = $urandom_range(0, 3) != 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bits(input logic [31:0] v, input int hi, input int lo);
        return int'((v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
    endfunction

    // Field placement straight from the format tables, built as a sum of shifted fields.
    function automatic logic [31:0] enc_model(input int f, input int rd, input int rs1, input int rs2,
                                              input int f3, input int f7, input logic [31:0] imm);
        int unsigned regs;
        regs = (rs1 << 15) | (f3 << 12);
        case (f)
            0: return (f7 << 25) | (rs2 << 20) | regs | (rd << 7) | 'h33;
            1: return ((f3 == 1 || f3 == 5) ? (f7 << 25) | (bits(imm, 4, 0) << 20) : bits(imm, 11, 0) << 20)
                      | regs | (rd << 7) | 'h13;
            2: return (bits(imm, 11, 0) << 20) | regs | (rd << 7) | 'h03;
            3: return (bits(imm, 11, 5) << 25) | (rs2 << 20) | regs | (bits(imm, 4, 0) << 7) | 'h23;
            4: return (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | (rs2 << 20) | regs
                      | (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7) | 'h63;
            5: return (imm & 32'hFFFFF000) | (rd << 7) | 'h37;
            6: return (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20)
                      | (bits(imm, 19, 12) << 12) | (rd << 7) | 'h6F;
            default: return 32'h13;
        endcase
    endfunction

    function automatic bit rej_model(input int f, input int f3, input logic [31:0] imm);
        int s;
        s = imm;
        if (!CHK_EN) return 1'b0;
        case (f)
            1: return (f3 == 1 || f3 == 5) ? (s < 0 || s > 31) : (s < -2048 || s > 2047);
            2, 3: return s < -2048 || s > 2047;
            4: return s < -4096 || s > 4094 || imm[0];
            5: return imm[11:0] != 12'd0;
            6: return s < -1048576 || s > 1048574 || imm[0];
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_word", 1, 0);
            else begin
                head = q.pop_front();
                chk("out_data", out_data, head[31:0]);
                chk("out_addr", out_addr, head[AW+31:32]);
            end
        end
    end

    // Called and returns 1ns after a rising edge.
    task automatic send(input int f, input int rd, input int rs1, input int rs2, input int f3, input int f7,
                        input logic [31:0] imm, input bit last, input logic [31:0] exp, input string tag);
        int n = 0;
        in_fmt = 3'(f); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, in_ready, 1);
        if (in_ready) begin
            if (rej_model(f, f3, imm)) ecnt = ecnt == 255 ? 255 : ecnt + 1;
            else begin
                q.push_back({addr_m, exp});
                addr_m++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic go(input logic [AW-1:0] b, input bit takes);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (takes) addr_m = b;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, q.size() == 0 && !out_valid, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_send(input bit last);
        int f, rd, rs1, rs2, f3, f7;
        logic [31:0] imm;
        f = $urandom_range(0, 7);
        rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
        f3 = $urandom_range(0, 7); f7 = $urandom_range(0, 127);
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = $urandom_range(0, 8191) - 4096;
            2: imm = $urandom_range(0, 63) - 16;
            default: imm = $urandom_range(0, 4194304) - 2097152;
        endcase
        if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
        if (f == 5 && $urandom_range(0, 1) == 1) imm[11:0] = 12'd0;
        send(f, rd, rs1, rs2, f3, f7, imm, last, enc_model(f, rd, rs1, rs2, f3, f7, imm), "rnd");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rdy_man = 1'b1;
        go(10'h010, 1'b1);
        send(1, 1, 0, 0, 0, 0, 32'd5, 1'b0, 32'h00500093, "addi");
        send(0, 3, 1, 2, 0, 0, 32'd0, 1'b0, 32'h002081B3, "add");
        send(3, 0, 1, 2, 2, 0, 32'd8, 1'b0, 32'h0020A423, "sw");
        send(4, 0, 0, 0, 0, 0, -32'sd4, 1'b0, 32'hFE000EE3, "beq");
        drain("basic");

        go(10'h200, 1'b0);
        send(0, 4, 5, 6, 0, 32, 32'd0, 1'b0, enc_model(0, 4, 5, 6, 0, 32, 0), "start_ignored");
        drain("start_ignored");

        rdy_man = 1'b0;
        send(1, 7, 1, 0, 1, 0, 32'd3, 1'b0, enc_model(1, 7, 1, 0, 1, 0, 3), "bp0");
        send(6, 1, 0, 0, 0, 0, 32'd2048, 1'b0, enc_model(6, 1, 0, 0, 0, 0, 2048), "bp1");
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        rdy_man = 1'b1;
        @(negedge clk);
        chk("full_pop_no_bypass", in_ready, 0);
        @(posedge clk);
        #1;
        send(5, 9, 0, 0, 0, 0, 32'h12345000, 1'b0, enc_model(5, 9, 0, 0, 0, 0, 32'h12345000), "bp2");
        drain("bp");

        send(1, 5, 1, 0, 0, 0, 32'd2048, 1'b0, enc_model(1, 5, 1, 0, 0, 0, 2048), "rej");
        @(negedge clk);
        chk("rej_err", err, CHK_EN);
        chk("rej_err_cnt", err_cnt, ecnt);
        chk("rej_no_word", out_valid, !CHK_EN);
        @(negedge clk);
        chk("rej_err_pulse", err, 0);
        @(posedge clk);
        #1;
        send(1, 2, 0, 0, 0, 0, 32'd1, 1'b0, enc_model(1, 2, 0, 0, 0, 0, 1), "after_rej");
        drain("rej");

        for (int i = 0; i < 260; i++)
            send(7, i % 32, 0, 0, 0, 0, 32'(i), 1'b0, 32'h13, "ill");
        drain("ill");
        chk("sat_err_cnt", err_cnt, ecnt);

        send(0, 1, 1, 1, 0, 0, 32'd0, 1'b1, enc_model(0, 1, 1, 1, 0, 0, 0), "last");
        drain("last");
        chk("done_set", done, 1);
        chk("done_in_ready", in_ready, 0);

        go(10'h3FF, 1'b1);
        chk("restart_done_clr", done, 0);
        send(2, 8, 2, 0, 2, 0, -32'sd2048, 1'b0, enc_model(2, 8, 2, 0, 2, 0, -32'sd2048), "wrap0");
        send(6, 1, 0, 0, 0, 0, 32'd1048574, 1'b1, enc_model(6, 1, 0, 0, 0, 0, 1048574), "wrap1");
        drain("wrap");
        chk("wrap_done", done, 1);
        chk("wrap_in_ready", in_ready, 0);

        go(10'($urandom), 1'b1);
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) rnd_send(i == 149);
        drain("rnd");
        rnd_mode = 1'b0;
        chk("rnd_done", done, 1);
        chk("rnd_err_cnt", err_cnt, ecnt);

        rdy_man = 1'b0;
        go(10'h000, 1'b1);
        send(0, 1, 2, 3, 0, 0, 32'd0, 1'b0, enc_model(0, 1, 2, 3, 0, 0, 0), "mid0");
        send(0, 4, 5, 6, 0, 0, 32'd0, 1'b0, enc_model(0, 4, 5, 6, 0, 0, 0), "mid1");
        rst_n = 1'b0;
        q.delete();
        ecnt = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_man = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_out_valid", out_valid, 0);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the core's instruction decoder: takes decoded RV32I fields over a valid/ready stream and assembles 32-bit instruction words.
- Words go through a 2-entry output FIFO and out on an instruction-memory write stream, with an internal auto-incrementing word address.
- Used by the self-test/boot program builder to fill instruction memory without an external assembler.

Parameters:
- ADDR_W, 10, width of the instruction-memory word address; the address counter wraps modulo 2^ADDR_W.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; loads base_addr and begins a program
- base_addr  input  ADDR_W  first word address of the program
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder accepts input this cycle
- in_fmt  input  3  format code (package enum)
- in_rd, in_rs1, in_rs2  input  5 each  register fields
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type, and I-type shifts)
- in_imm  input  32  immediate, sign-extended byte offset
- in_last  input  1  marks the final instruction of the program
- out_valid  output  1  encoded word available
- out_ready  input  1  memory side accepts the word
- out_addr  output  ADDR_W  word address for out_data
- out_data  output  32  encoded instruction
- done  output  1  level; program fully drained
- err  output  1  one-cycle pulse; an input was rejected
- err_cnt  output  ERR_CNT_W  saturating count of rejected inputs

Behaviour:
- Reset: async assert clears FIFO and address/error counters, state=IDLE. Outputs: in_ready=0, out_valid=0, out_addr=0, out_data=0, done=0, err=0, err_cnt=0.
- States:
  - IDLE: start -> RUN (addr<=base_addr, err_cnt kept).
  - RUN: accept inputs. An accepted in_last sets last_seen; when last_seen and FIFO empty -> DONE.
  - DONE: done=1; start -> RUN (clears done and last_seen, reloads addr).
- start outside IDLE/DONE is ignored.
- in_ready = (state==RUN) && !fifo_full && !last_seen. No same-cycle bypass: FIFO full with a pop in that cycle still gives in_ready=0.
- Latency: input accepted at cycle N -> word visible at FIFO head; out_valid at N+1 at the earliest.
- out transfer on out_valid&&out_ready. Each pushed entry carries its address; addr increments per push and wraps 2^ADDR_W-1 -> 0.
- Format codes and opcodes:
  - R=0 (0110011): funct7|rs2|rs1|f3|rd|op.
  - I=1 (0010011): imm[11:0]|rs1|f3|rd|op. If f3 is 001 or 101: [31:25]=funct7, [24:20]=imm[4:0].
  - LOAD=2 (0000011): same layout as I.
  - S=3 (0100011): imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B=4 (1100011): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U=5 (0110111): imm[31:12]|rd|op.
  - J=6 (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - fmt 7: illegal.
- Unused fields are ignored.
- Reject rules (checked when the feature below is enabled):
  - I/LOAD/S: imm outside -2048..2047.
  - I shifts: imm outside 0..31.
  - B: imm outside -4096..4094, or odd.
  - J: imm outside ±1 MiB (-1048576..1048574), or odd.
  - U: imm[11:0]!=0.
  - Any fmt 7.
- A rejected input is still handshaken (consumed): no push, no addr increment, err pulses at N+1, err_cnt increments and saturates at all-ones. A rejected in_last still sets last_seen.
- Reset mid-program drops all queued words.

Optional Feature:
- Macro INST_ENC_CHECK_EN.
- Defined: reject rules active as above.
- Undefined: immediates are silently truncated to field width, fmt 7 encodes as 32'h00000013 (nop), err=0 and err_cnt=0 constant.

Decomposition:
- Package inst_enc_pkg: format enum (FMT_R..FMT_J, FMT_ILL), the seven opcode constants (shared with the decoder), and immediate range constants.
- Sub-module inst_enc_fifo: 2-entry FIFO carrying {addr, data}, with full/empty flags.
- Encode and check logic stays combinational inside the top.

Test Plan:
- start, base_addr=0x10; send I addi rd=1,rs1=0,imm=5 -> out_data=0x00500093, out_addr=0x10.
- R add rd=3,rs1=1,rs2=2 -> 0x002081B3. S sw rs1=1,rs2=2,f3=2,imm=8 -> 0x0020A423. B beq x0,x0,imm=-4 -> 0xFE000EE3. Addresses must be consecutive.
- out_ready=0, push 3 inputs -> in_ready low after 2 accepts; release out_ready -> third accepted, order preserved.
- (CHECK_EN) I imm=2048 -> consumed, no out_valid, err pulse at N+1, err_cnt=1; next valid word takes the unconsumed address.
- base_addr=2^ADDR_W-1, send 2 words with in_last on the second -> addresses 0x3FF then 0x000; done=1 after drain; in_ready=0 in DONE.
- Assert rst_n low with 2 words queued -> out_valid=0 immediately, state IDLE, err_cnt=0.
